// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder: boot/run state,
// default NOP encoding and address index/range utilities.
package mem_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    typedef enum logic {
        BOOT_LOAD = 1'b0,
        RUN       = 1'b1
    } state_t;

    function automatic int unsigned idx_w(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Word-aligned and inside a memory of the given depth.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < words);
    endfunction

endpackage

// File: rtl/mem_responder_packer.sv
// Boot byte-stream packer: places loader bytes LSB-first into a 32-bit word
// and strobes the word out on the 4th byte or on the image's last byte.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        last,
    input  logic [7:0]  ld_byte,
    output logic [31:0] word,
    output logic        word_we
);

    logic [1:0]  lane;
    logic [31:0] acc;

    // Lanes above the current one are still zero in acc, so a short final word comes out zero-padded.
    always_comb begin
        word = acc;
        word[{lane, 3'b000} +: 8] = ld_byte;
        word_we = accept && ((lane == 2'd3) || last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane <= '0;
            acc  <= '0;
        end else if (accept) begin
            if (word_we) begin
                lane <= '0;
                acc  <= '0;
            end else begin
                lane <= lane + 2'd1;
                acc  <= word;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Harvard IMEM/DMEM responder for the core with a boot loader that fills
// IMEM from a byte stream and holds the core in reset until the image is in.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR  = NOP_DEFAULT,
    parameter bit          BOOT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_rst_n,
    input  logic        cs_i_n,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    input  logic        cs_d_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] Data_write,
    output logic [31:0] d_data,
    output logic        err,
    output logic [15:0] ld_words
);

    localparam int unsigned IW = idx_w(IMEM_WORDS);
    localparam int unsigned DW = idx_w(DMEM_WORDS);

    state_t      state, state_nx;
    logic        ld_ready_nx, core_rst_nx;
    logic        run, accept, pk_we, ld_full, i_ok, d_ok;
    logic [31:0] pk_word;
    logic [IW-1:0] i_idx;
    logic [DW-1:0] d_idx;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    assign run     = (state == RUN);
    assign accept  = ld_valid && ld_ready && (state == BOOT_LOAD);
    assign ld_full = (ld_words == 16'(IMEM_WORDS));
    assign i_ok    = addr_ok(i_addr, IMEM_WORDS);
    assign d_ok    = addr_ok(d_addr, DMEM_WORDS);
    assign i_idx   = i_addr[IW+1:2];
    assign d_idx   = d_addr[DW+1:2];

    boot_word_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .last    (ld_last),
        .ld_byte (ld_byte),
        .word    (pk_word),
        .word_we (pk_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT_EN ? BOOT_LOAD : RUN;
            ld_ready   <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= state_nx;
            ld_ready   <= ld_ready_nx;
            core_rst_n <= core_rst_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if ((state == BOOT_LOAD) && accept && ld_last)
            state_nx = RUN;
    end

    always_comb begin
        ld_ready_nx = (state == BOOT_LOAD);
        core_rst_nx = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_data   <= NOP_INSTR;
            d_data   <= '0;
            err      <= 1'b0;
            ld_words <= '0;
        end else if (!run) begin
            i_data <= NOP_INSTR;
            d_data <= '0;
            if (pk_we) begin
                if (ld_full) err <= 1'b1;
                else         ld_words <= ld_words + 16'd1;
            end
        end else begin
            if (!cs_i_n) begin
                if (i_ok) begin
                    i_data <= imem[i_idx];
                end else begin
                    i_data <= NOP_INSTR;
                    err    <= 1'b1;
                end
            end
            if (!cs_d_n && (rd || wr)) begin
                if (!d_ok) begin
                    d_data <= '0;
                    err    <= 1'b1;
                end else if (rd) begin
                    d_data <= dmem[d_idx];
                    if (wr) err <= 1'b1;
                end
            end
        end
    end

    // Arrays are never reset; contents survive rst and a reload.
    always_ff @(posedge clk) begin
        if (!rst && !run && pk_we && !ld_full)
            imem[ld_words[IW-1:0]] <= pk_word;
        if (!rst && run && !cs_d_n && wr && d_ok)
            dmem[d_idx] <= Data_write;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: boot loading, fetch,
// data access, error flag and overflow saturation with a 16-word IMEM.
module tb_mem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, ld_valid, ld_last, ld_ready, core_rst_n;
    logic [7:0]  ld_byte;
    logic        cs_i_n, cs_d_n, rd, wr, err;
    logic [31:0] i_addr, i_data, d_addr, Data_write, d_data;
    logic [15:0] ld_words;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .IMEM_WORDS (16),
        .DMEM_WORDS (16),
        .NOP_INSTR  (32'h0000_0013),
        .BOOT_EN    (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .core_rst_n (core_rst_n),
        .cs_i_n     (cs_i_n),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .cs_d_n     (cs_d_n),
        .rd         (rd),
        .wr         (wr),
        .d_addr     (d_addr),
        .Data_write (Data_write),
        .d_data     (d_data),
        .err        (err),
        .ld_words   (ld_words)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
        cs_i_n = 1'b1; i_addr = '0; cs_d_n = 1'b1; rd = 1'b0; wr = 1'b0;
        d_addr = '0; Data_write = '0;
        tick();
        tick();
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_i_data", i_data, NOP);
        chk("rst_d_data", d_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ld_words", 32'(ld_words), 32'd0);
        rst = 1'b0;
        tick();
        chk("ld_ready_up", 32'(ld_ready), 32'd1);

        // Image 1: one full word
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        send_byte(8'h00, 1'b1);
        chk("img1_ld_words", 32'(ld_words), 32'd1);
        chk("img1_core_rst_early", 32'(core_rst_n), 32'd0);
        tick();
        chk("img1_core_rst_n", 32'(core_rst_n), 32'd1);
        chk("img1_ld_ready_low", 32'(ld_ready), 32'd0);
        cs_i_n = 1'b0; i_addr = 32'h0;
        tick();
        chk("img1_fetch0", i_data, 32'h0050_0013);
        cs_i_n = 1'b1; i_addr = 32'h4;
        tick();
        chk("fetch_hold", i_data, 32'h0050_0013);
        chk("img1_err", 32'(err), 32'd0);

        // Image 2: six bytes, short last word
        do_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        chk("img2_ld_words", 32'(ld_words), 32'd2);
        tick();
        cs_i_n = 1'b0; i_addr = 32'h4;
        tick();
        chk("img2_fetch4", i_data, 32'h0000_BBAA);
        i_addr = 32'h0;
        tick();
        chk("img2_fetch0", i_data, 32'h4433_2211);
        cs_i_n = 1'b1;

        // Data store / load
        cs_d_n = 1'b0; wr = 1'b1; d_addr = 32'h10; Data_write = 32'hDEAD_BEEF;
        tick();
        chk("store_d_hold", d_data, 32'd0);
        wr = 1'b0; rd = 1'b1;
        tick();
        chk("load_10", d_data, 32'hDEAD_BEEF);
        cs_d_n = 1'b1; rd = 1'b0;
        tick();
        chk("load_hold", d_data, 32'hDEAD_BEEF);
        chk("data_err_clean", 32'(err), 32'd0);
        cs_d_n = 1'b0; rd = 1'b1; wr = 1'b1; Data_write = 32'h1234_5678;
        tick();
        chk("rdwr_old", d_data, 32'hDEAD_BEEF);
        chk("rdwr_err", 32'(err), 32'd1);
        wr = 1'b0;
        tick();
        chk("rdwr_new", d_data, 32'h1234_5678);
        rd = 1'b0; wr = 1'b1; Data_write = 32'hDEAD_BEEF;
        tick();
        wr = 1'b0; rd = 1'b1; d_addr = 32'h40;
        tick();
        chk("load_oor_zero", d_data, 32'd0);
        cs_d_n = 1'b1; rd = 1'b0;
        cs_i_n = 1'b0; i_addr = 32'h2;
        tick();
        chk("fetch_misaligned", i_data, NOP);
        cs_i_n = 1'b1;

        // Reset mid-RUN, junk store attempted during boot
        rst = 1'b1;
        cs_d_n = 1'b0; wr = 1'b1; d_addr = 32'h10; Data_write = 32'hBAD0_BAD0;
        tick();
        chk("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
        chk("midrst_err", 32'(err), 32'd0);
        send_byte(8'h99, 1'b1);
        cs_d_n = 1'b1; wr = 1'b0;
        chk("img3_ld_words", 32'(ld_words), 32'd1);
        tick();
        chk("img3_core_rst_n", 32'(core_rst_n), 32'd1);
        cs_i_n = 1'b0; i_addr = 32'h0;
        tick();
        chk("img3_fetch0", i_data, 32'h0000_0099);
        chk("img3_err_clean", 32'(err), 32'd0);
        i_addr = 32'h1;
        tick();
        chk("misaligned_nop", i_data, NOP);
        chk("misaligned_err", 32'(err), 32'd1);
        cs_i_n = 1'b1;
        cs_d_n = 1'b0; rd = 1'b1; d_addr = 32'h10;
        tick();
        chk("dmem_retained", d_data, 32'hDEAD_BEEF);
        cs_d_n = 1'b1; rd = 1'b0;

        // Overflow: 17 words into a 16-word IMEM
        do_reset();
        for (int w = 0; w < 17; w++) begin
            for (int b = 0; b < 4; b++)
                send_byte(8'(w + 1), (w == 16) && (b == 3));
        end
        chk("ovf_ld_words", 32'(ld_words), 32'd16);
        chk("ovf_err", 32'(err), 32'd1);
        tick();
        cs_i_n = 1'b0; i_addr = 32'h0;
        tick();
        chk("ovf_word0", i_data, 32'h0101_0101);
        i_addr = 32'h3C;
        tick();
        chk("ovf_word15", i_data, 32'h1010_1010);
        i_addr = 32'h40;
        tick();
        chk("fetch_oor_nop", i_data, NOP);
        cs_i_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
